// File: rtl/sdr_pkg.sv
// Shared definitions for the single-ADC FM demodulation datapath.
// Phase constants are common to the sequencer and the differentiator.
package sdr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    DRAIN
  } seq_state_t;

  localparam int unsigned PHASES  = 8;
  localparam int unsigned I_PHASE = 4;
  localparam int unsigned Q_PHASE = 6;

  localparam logic [2:0] LAST_PHASE = 3'(PHASES - 1);

endpackage

// File: rtl/demod_sequencer_if.sv
// Valid/ready stream carrying one demodulated word per frame.
interface demod_sequencer_if #(
  parameter int unsigned DW = 10
);

  logic          demod_valid;
  logic [DW-1:0] demod_data;
  logic          demod_ready;

  modport master (
    output demod_valid,
    output demod_data,
    input  demod_ready
  );

  modport slave (
    input  demod_valid,
    input  demod_data,
    output demod_ready
  );

endinterface

// File: rtl/demod_out_reg.sv
// Valid/ready holding register for demodulated words.
// A capture that finds the register full and not draining is dropped and flagged.
module demod_out_reg #(
  parameter int unsigned DW = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 capture,
  input  logic [DW-1:0]        din,
  input  logic                 clr_ovr,
  output logic                 overrun,
  demod_sequencer_if.master    out
);

  logic can_load;
  logic drop;

  always_comb begin
    can_load = !out.demod_valid || out.demod_ready;
    drop     = capture && !can_load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out.demod_valid <= 1'b0;
      out.demod_data  <= '0;
      overrun         <= 1'b0;
    end else begin
      if (capture && can_load) begin
        out.demod_data  <= din;
        out.demod_valid <= 1'b1;
      end else if (out.demod_valid && out.demod_ready) begin
        out.demod_valid <= 1'b0;
      end

      // A new drop takes priority over a clear in the same cycle.
      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/demod_sequencer.sv
// Sequencer for the FM demod differentiator: phase tagging, pipeline priming
// and one captured result per 8-sample frame.
module demod_sequencer
  import sdr_pkg::*;
#(
  parameter int unsigned DW           = 10,
  parameter int unsigned PRIME_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              clr_ovr,
  input  logic              adc_valid,
  input  logic [DW-1:0]     adc_data,
  output logic              dp_en,
  output logic [DW-1:0]     dp_x,
  output logic [2:0]        dp_channel,
  input  logic [DW-1:0]     dp_out,
  demod_sequencer_if.master demod,
  output logic              busy,
  output logic              overrun
);

  localparam logic [3:0] PF = 4'(PRIME_FRAMES);

  seq_state_t state, state_nxt;
  logic [2:0] phase, phase_nxt;
  logic [3:0] prime_cnt, prime_nxt;
  logic       drain_cap, drain_cap_nxt;
  logic       accept;
  logic       frame_end;
  logic       sched;
  logic       cap_p1, cap_p2;

  always_comb begin
    accept        = adc_valid && (state != IDLE);
    frame_end     = accept && (phase == LAST_PHASE);
    state_nxt     = state;
    phase_nxt     = accept ? phase + 3'd1 : phase;
    prime_nxt     = prime_cnt;
    drain_cap_nxt = drain_cap;
    sched         = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt     = PRIME;
          phase_nxt     = '0;
          prime_nxt     = '0;
          drain_cap_nxt = 1'b0;
        end
      end
      PRIME: begin
        if (frame_end) begin
          prime_nxt = prime_cnt + 4'd1;
        end
        if (stop) begin
          state_nxt     = (phase == '0) ? IDLE : DRAIN;
          drain_cap_nxt = 1'b0;
        end else if (frame_end && (prime_nxt == PF)) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        sched = frame_end;
        if (stop) begin
          state_nxt     = (phase == '0) ? IDLE : DRAIN;
          drain_cap_nxt = 1'b1;
        end
      end
      DRAIN: begin
        sched = frame_end && drain_cap;
        if (frame_end) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= '0;
      prime_cnt <= '0;
      drain_cap <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      prime_cnt <= prime_nxt;
      drain_cap <= drain_cap_nxt;
    end
  end

  // Capture lands two cycles after the frame end: one for the dp_* register,
  // one for the differentiator to produce its result.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_en      <= 1'b0;
      dp_x       <= '0;
      dp_channel <= '0;
      cap_p1     <= 1'b0;
      cap_p2     <= 1'b0;
    end else begin
      dp_en  <= accept;
      cap_p1 <= sched;
      cap_p2 <= cap_p1;
      if (accept) begin
        dp_x       <= adc_data;
        dp_channel <= phase;
      end
    end
  end

  assign busy = (state != IDLE);

  demod_out_reg #(
    .DW(DW)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .capture (cap_p2),
    .din     (dp_out),
    .clr_ovr (clr_ovr),
    .overrun (overrun),
    .out     (demod)
  );

endmodule

// File: tb/tb_demod_sequencer.sv
// Randomized scoreboard bench for demod_sequencer against a sample-count model.
module tb_demod_sequencer;

  localparam int unsigned DW = 10;
  localparam int PF = 2;

  logic          clk = 1'b0;
  logic          rst, start, stop, clr_ovr, adc_valid, rdy;
  logic [DW-1:0] adc_data, dp_out;
  logic          dp_en, busy, overrun;
  logic [DW-1:0] dp_x;
  logic [2:0]    dp_channel;

  demod_sequencer_if #(.DW(DW)) dif ();
  assign dif.demod_ready = rdy;

  demod_sequencer #(
    .DW(DW),
    .PRIME_FRAMES(PF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .clr_ovr    (clr_ovr),
    .adc_valid  (adc_valid),
    .adc_data   (adc_data),
    .dp_en      (dp_en),
    .dp_x       (dp_x),
    .dp_channel (dp_channel),
    .dp_out     (dp_out),
    .demod      (dif),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 sequencing, 2 finishing the last frame.
  int            mode = 0;
  int            samples = 0;
  bit            drain_cap = 0;
  int            cyc = 0;
  int            pend[$];
  logic [DW-1:0] sbq[$];
  logic          e_en = 0, mvalid = 0, movr = 0;
  logic [DW-1:0] e_x = '0, mdata = '0;
  logic [2:0]    e_ch = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_update();
    bit acc, fe, drop;
    int fidx;
    cyc++;
    if (rst) begin
      mode = 0; samples = 0; drain_cap = 0;
      pend.delete(); sbq.delete();
      mvalid = 0; mdata = '0; movr = 0;
      e_en = 0; e_x = '0; e_ch = '0;
    end else begin
      drop = 0;
      if (pend.size() != 0 && pend[0] == cyc) begin
        void'(pend.pop_front());
        if (!mvalid || rdy) begin
          mvalid = 1; mdata = dp_out; sbq.push_back(dp_out);
        end else begin
          drop = 1;
        end
      end else if (mvalid && rdy) begin
        mvalid = 0;
      end
      if (drop) movr = 1;
      else if (clr_ovr) movr = 0;

      acc  = adc_valid && (mode != 0);
      fe   = acc && (samples % 8 == 7);
      fidx = samples / 8;
      e_en = acc;
      if (acc) begin
        e_x  = adc_data;
        e_ch = 3'(samples % 8);
      end
      if (fe && ((mode == 1 && fidx >= PF) || (mode == 2 && drain_cap)))
        pend.push_back(cyc + 2);

      case (mode)
        0: if (start) begin mode = 1; samples = 0; end
        1: if (stop) begin
             if (samples % 8 == 0) mode = 0;
             else begin mode = 2; drain_cap = (fidx >= PF); end
           end
        default: if (fe) mode = 0;
      endcase
      if (acc) samples++;
    end
  endtask

  task automatic step(input bit r, s, p, av, rd, co);
    @(posedge clk);
    model_update();
    #1;
    rst = r; start = s; stop = p; adc_valid = av; rdy = rd; clr_ovr = co;
    adc_data = DW'($urandom);
    dp_out   = DW'($urandom);
  endtask

  // Monitor: per-cycle output compare plus scoreboard pop on each transfer.
  initial begin
    forever begin
      @(negedge clk);
      chk("dp_en", 32'(dp_en), 32'(e_en));
      chk("dp_x", 32'(dp_x), 32'(e_x));
      chk("dp_channel", 32'(dp_channel), 32'(e_ch));
      chk("busy", 32'(busy), 32'(mode != 0));
      chk("demod_valid", 32'(dif.demod_valid), 32'(mvalid));
      chk("demod_data", 32'(dif.demod_data), 32'(mdata));
      chk("overrun", 32'(overrun), 32'(movr));
      if (dif.demod_valid === 1'b1 && rdy === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL xfer at cycle %0d: got word %0h expected no word", cyc, dif.demod_data);
        end else begin
          chk("xfer_word", 32'(dif.demod_data), 32'(sbq.pop_front()));
        end
      end
    end
  end

  initial begin
    rst = 1; start = 0; stop = 0; adc_valid = 0; rdy = 0; clr_ovr = 0;
    adc_data = '0; dp_out = '0;
    repeat (3) step(1, 0, 0, 0, 0, 0);

    // start together with stop in idle, then continuous samples
    step(0, 1, 1, 0, 1, 0);
    repeat (60) step(0, 0, 0, 1, 1, 0);
    // start during run is ignored
    step(0, 1, 0, 1, 1, 0);
    repeat (20) step(0, 0, 0, 1, 1, 0);

    // backpressure across several frame ends, then clear
    repeat (40) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 1);
    repeat (10) step(0, 0, 0, 1, 1, 0);

    // reset in the middle of running
    step(1, 0, 0, 1, 1, 0);
    step(0, 1, 0, 1, 1, 0);
    repeat (30) step(0, 0, 0, 1, 1, 0);

    repeat (4000)
      step($urandom_range(0, 999) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);

    // wind down and flush the output register
    step(0, 0, 1, 0, 1, 0);
    repeat (20) step(0, 0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    repeat (20) step(0, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
